rv32v_vtype_spec_queue: RTL and testbench

Multi-entry speculative vtype/vl tracker for the vector unit, replacing the single-entry decode shadow. Holds the architectural vtype/vl and up to DEPTH in-flight vsetvl results, so several vsetvl/vsetvli/vsetivli instructions can be outstanding between decode and retire. Decode reads the youngest speculative state. Retire commits the oldest entry. A pipeline flush discards all speculative entries.

---
 rtl/rv32v_types_pkg.sv | 44 ++++
 rtl/rv32v_vtype_legalize.sv | 73 +++++++
 rtl/rv32v_vtype_spec_queue.sv | 103 ++++++++++
 tb/tb_rv32v_vtype_spec_queue.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/rv32v_types_pkg.sv
// Shared vtype/vl types for the speculative vtype tracker.
package rv32v_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    LMUL_1    = 3'b000,
    LMUL_2    = 3'b001,
    LMUL_4    = 3'b010,
    LMUL_8    = 3'b011,
    LMUL_RSVD = 3'b100,
    LMUL_F8   = 3'b101,
    LMUL_F4   = 3'b110,
    LMUL_F2   = 3'b111
  } vlmul_t;

  typedef enum logic [2:0] {
    SEW_8   = 3'b000,
    SEW_16  = 3'b001,
    SEW_32  = 3'b010,
    SEW_64  = 3'b011,
    SEW_R4  = 3'b100,
    SEW_R5  = 3'b101,
    SEW_R6  = 3'b110,
    SEW_R7  = 3'b111
  } vsew_t;

  typedef struct packed {
    logic   vill;
    logic   vma;
    logic   vta;
    vsew_t  vsew;
    vlmul_t vlmul;
  } vtype_t;

  typedef struct packed {
    vtype_t vtype;
    word_t  vl;
  } vspec_entry_t;

  localparam vtype_t VTYPE_ILLEGAL = '{vill: 1'b1, vma: 1'b0, vta: 1'b0,
                                       vsew: SEW_8, vlmul: LMUL_1};

endpackage

// File: rtl/rv32v_vtype_legalize.sv
// Combinational vtype legality check, VLMAX and vl selection.
// RV32V_AGNOSTIC_EN: accept and keep vta/vma instead of treating them as illegal.
module rv32v_vtype_legalize
  import rv32v_types_pkg::*;
#(
  parameter int unsigned VLEN = 128,
  parameter int unsigned ELEN = 32
) (
  input  word_t  vtype_in,
  input  word_t  avl_in,
  input  logic   avl_max,
  input  logic   vkeepvl,
  input  word_t  vl_cur,
  output vtype_t vtype_out,
  output word_t  vl_out,
  output word_t  vlmax
);

  localparam int unsigned ELEN_LOG2 = $clog2(ELEN);

  logic [3:0] sew_log2;
  logic [2:0] frac_shift;
  logic       illegal;
  logic       agnostic_bad;
  word_t      base;
  word_t      vlmax_raw;

  always_comb begin
`ifdef RV32V_AGNOSTIC_EN
    agnostic_bad = 1'b0;
`else
    agnostic_bad = |vtype_in[7:6];
`endif
    sew_log2   = 4'd3 + {2'b00, vtype_in[4:3]};
    // 101/110/111 encode 1/8, 1/4, 1/2: the right-shift is the two's complement of the code
    frac_shift = 3'd0 - vtype_in[2:0];
    illegal    = vtype_in[5]
               | (sew_log2 > 4'(ELEN_LOG2))
               | (vtype_in[2:0] == LMUL_RSVD)
               | (vtype_in[2] && (({1'b0, sew_log2} + {2'b00, frac_shift}) > 5'(ELEN_LOG2)))
               | (|vtype_in[31:8])
               | agnostic_bad;

    base      = word_t'(VLEN) >> sew_log2;
    vlmax_raw = vtype_in[2] ? (base >> frac_shift) : (base << vtype_in[1:0]);
    vlmax     = illegal ? '0 : vlmax_raw;

    if (illegal)
      vl_out = '0;
    else if (vkeepvl)
      vl_out = (vl_cur < vlmax) ? vl_cur : vlmax;
    else if (avl_max)
      vl_out = vlmax;
    else
      vl_out = (avl_in < vlmax) ? avl_in : vlmax;

    if (illegal) begin
      vtype_out = VTYPE_ILLEGAL;
    end else begin
      vtype_out.vill  = 1'b0;
`ifdef RV32V_AGNOSTIC_EN
      vtype_out.vma   = vtype_in[7];
      vtype_out.vta   = vtype_in[6];
`else
      vtype_out.vma   = 1'b0;
      vtype_out.vta   = 1'b0;
`endif
      vtype_out.vsew  = vsew_t'(vtype_in[5:3]);
      vtype_out.vlmul = vlmul_t'(vtype_in[2:0]);
    end
  end

endmodule

// File: rtl/rv32v_vtype_spec_queue.sv
// Speculative vtype/vl queue: architectural state plus DEPTH in-flight vsetvl results.
// RV32V_AGNOSTIC_EN (see rv32v_vtype_legalize) controls vta/vma acceptance.
module rv32v_vtype_spec_queue
  import rv32v_types_pkg::*;
#(
  parameter int unsigned VLEN  = 128,
  parameter int unsigned ELEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  word_t                    vtype_in,
  input  word_t                    avl_in,
  input  logic                     avl_max,
  input  logic                     vkeepvl,
  input  logic                     commit,
  input  logic                     flush,
  output vtype_t                   vtype_spec,
  output word_t                    vl_spec,
  output vtype_t                   vtype_arch,
  output word_t                    vl_arch,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  vspec_entry_t q [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  vtype_t        new_vtype;
  word_t         new_vl;
  word_t         new_vlmax;
  logic          do_push;
  logic          do_commit;
  logic [CW-1:0] count_next;
  vspec_entry_t  arch_next;
  vspec_entry_t  spec_next;

  // vl_spec always mirrors the youngest entry, so it is the pre-commit chaining source
  rv32v_vtype_legalize #(.VLEN(VLEN), .ELEN(ELEN)) u_legalize (
    .vtype_in  (vtype_in),
    .avl_in    (avl_in),
    .avl_max   (avl_max),
    .vkeepvl   (vkeepvl),
    .vl_cur    (vl_spec),
    .vtype_out (new_vtype),
    .vl_out    (new_vl),
    .vlmax     (new_vlmax)
  );

  assign push_ready = ~full | commit;

  always_comb begin
    do_commit  = commit & ~empty;
    do_push    = push_valid & push_ready & ~flush;
    count_next = flush ? '0 : (count + CW'(do_push) - CW'(do_commit));
    arch_next  = do_commit ? q[head] : '{vtype: vtype_arch, vl: vl_arch};
    if (flush || count_next == '0)
      spec_next = arch_next;
    else if (do_push)
      spec_next = '{vtype: new_vtype, vl: new_vl};
    else
      spec_next = '{vtype: vtype_spec, vl: vl_spec};
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < DEPTH; i++) q[i] <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      vtype_arch <= VTYPE_ILLEGAL;
      vl_arch    <= '0;
      vtype_spec <= VTYPE_ILLEGAL;
      vl_spec    <= '0;
    end else begin
      if (do_push) q[tail] <= '{vtype: new_vtype, vl: new_vl};
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (do_commit) head <= head + 1'b1;
        if (do_push)   tail <= tail + 1'b1;
      end
      count      <= count_next;
      empty      <= (count_next == '0);
      full       <= (count_next == CW'(DEPTH));
      vtype_arch <= arch_next.vtype;
      vl_arch    <= arch_next.vl;
      vtype_spec <= spec_next.vtype;
      vl_spec    <= spec_next.vl;
    end
  end

endmodule

// File: tb/tb_rv32v_vtype_spec_queue.sv
// Directed self-checking bench for rv32v_vtype_spec_queue (VLEN=128, ELEN=32, DEPTH=4).
module tb_rv32v_vtype_spec_queue;
  import rv32v_types_pkg::*;

  logic         CLK = 1'b0;
  logic         nRST;
  logic         push_valid;
  logic         push_ready;
  logic [31:0]  vtype_in;
  logic [31:0]  avl_in;
  logic         avl_max;
  logic         vkeepvl;
  logic         commit;
  logic         flush;
  vtype_t       vtype_spec;
  logic [31:0]  vl_spec;
  vtype_t       vtype_arch;
  logic [31:0]  vl_arch;
  logic [2:0]   count;
  logic         empty;
  logic         full;

  int checks = 0;
  int errors = 0;

  rv32v_vtype_spec_queue #(.VLEN(128), .ELEN(32), .DEPTH(4)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .vtype_in   (vtype_in),
    .avl_in     (avl_in),
    .avl_max    (avl_max),
    .vkeepvl    (vkeepvl),
    .commit     (commit),
    .flush      (flush),
    .vtype_spec (vtype_spec),
    .vl_spec    (vl_spec),
    .vtype_arch (vtype_arch),
    .vl_arch    (vl_arch),
    .count      (count),
    .empty      (empty),
    .full       (full)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    push_valid = 1'b0; vtype_in = '0; avl_in = '0; avl_max = 1'b0;
    vkeepvl = 1'b0; commit = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic push(input logic [31:0] vt, input logic [31:0] avl,
                      input logic amax, input logic keep);
    push_valid = 1'b1; vtype_in = vt; avl_in = avl; avl_max = amax; vkeepvl = keep;
  endtask

  initial begin
    nRST = 1'b0;
    idle();
    #12 nRST = 1'b1;
    #1;
    chk("rst_vtype_arch", 32'(vtype_arch), 32'h100);
    chk("rst_vl_arch",    vl_arch, 0);
    chk("rst_vtype_spec", 32'(vtype_spec), 32'h100);
    chk("rst_vl_spec",    vl_spec, 0);
    chk("rst_count",      32'(count), 0);
    chk("rst_empty",      32'(empty), 1);
    chk("rst_full",       32'(full), 0);
    chk("rst_ready",      32'(push_ready), 1);

    // SEW32/LMUL1, avl 10 -> vl 4
    push(32'h10, 32'd10, 1'b0, 1'b0); tick();
    chk("p1_vl_spec",    vl_spec, 4);
    chk("p1_vtype_spec", 32'(vtype_spec), 32'h010);
    chk("p1_count",      32'(count), 1);
    commit = 1'b1; tick();
    chk("c1_vl_arch",    vl_arch, 4);
    chk("c1_vtype_arch", 32'(vtype_arch), 32'h010);
    chk("c1_empty",      32'(empty), 1);
    commit = 1'b1; tick();
    chk("c_empty_ignored", vl_arch, 4);
    chk("c_empty_count",   32'(count), 0);

    // Fill: SEW8/LMUL8 avl_max, keepvl chain, two illegal forms
    push(32'h03, 32'd0, 1'b1, 1'b0); tick();
    chk("max_vl", vl_spec, 128);
    push(32'h10, 32'd0, 1'b0, 1'b1); tick();
    chk("keep_vl", vl_spec, 4);
    push(32'h17, 32'd10, 1'b0, 1'b0); tick();
    chk("frac_vill", 32'(vtype_spec), 32'h100);
    chk("frac_vl",   vl_spec, 0);
    push(32'h04, 32'd10, 1'b0, 1'b0); tick();
    chk("rsvd_vill", 32'(vtype_spec), 32'h100);
    chk("full_flag", 32'(full), 1);
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(push_ready), 0);
    commit = 1'b1; #1;
    chk("full_commit_ready", 32'(push_ready), 1);
    // push SEW8/LMUL1/4 avl 100 -> VLMAX 4 while committing entry 0
    push(32'h06, 32'd100, 1'b0, 1'b0); tick();
    chk("pc_count",      32'(count), 4);
    chk("pc_vtype_arch", 32'(vtype_arch), 32'h003);
    chk("pc_vl_arch",    vl_arch, 128);
    chk("pc_vtype_spec", 32'(vtype_spec), 32'h006);
    chk("pc_vl_spec",    vl_spec, 4);

    flush = 1'b1; tick();
    chk("fl_empty",   32'(empty), 1);
    chk("fl_vl_spec", vl_spec, 128);
    chk("fl_arch",    vl_arch, 128);

    push(32'h11, 32'd5, 1'b0, 1'b0); tick();
    push(32'h00, 32'd100, 1'b0, 1'b0); tick();
    chk("sew8_vl", vl_spec, 16);
    push(32'h08, 32'd0, 1'b0, 1'b1); tick();
    chk("keep16_vl", vl_spec, 8);
    chk("three_count", 32'(count), 3);
    commit = 1'b1; flush = 1'b1;
    push(32'h03, 32'd0, 1'b1, 1'b0); tick();
    chk("cf_vtype_arch", 32'(vtype_arch), 32'h011);
    chk("cf_vl_arch",    vl_arch, 5);
    chk("cf_empty",      32'(empty), 1);
    chk("cf_count",      32'(count), 0);
    chk("cf_vl_spec",    vl_spec, 5);
    chk("cf_vtype_spec", 32'(vtype_spec), 32'h011);

    // vta=1, SEW16/LMUL2, avl 20 -> VLMAX 16
    push(32'h49, 32'd20, 1'b0, 1'b0); tick();
`ifdef RV32V_AGNOSTIC_EN
    chk("vta_vtype", 32'(vtype_spec), 32'h049);
    chk("vta_vl",    vl_spec, 16);
`else
    chk("vta_vtype", 32'(vtype_spec), 32'h100);
    chk("vta_vl",    vl_spec, 0);
`endif
    push(32'h110, 32'd20, 1'b0, 1'b0); tick();
    chk("hi_bits_vill", 32'(vtype_spec), 32'h100);
    chk("hi_bits_count", 32'(count), 2);

    // Asynchronous reset mid-operation
    #2 nRST = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_vtype_arch", 32'(vtype_arch), 32'h100);
    chk("arst_vl_arch", vl_arch, 0);
    #10 nRST = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
